// File: rtl/csa_pkg.sv
// Shared types and constants for the wide carry-skip add/subtract sequencer.
package csa_pkg;

    localparam int SLICE_W   = 16;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_t;

endpackage

// File: rtl/csa_slice16.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed by its
// group propagate so a fully-propagating block forwards its carry-in directly.
module csa_slice16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p_bit;
    logic [15:0] g_bit;
    logic [3:0]  blk_prop;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_blk
            assign p_bit[4*gi +: 4] = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign g_bit[4*gi +: 4] = a[4*gi +: 4] & b[4*gi +: 4];
            assign blk_prop[gi]     = &p_bit[4*gi +: 4];
        end
    endgenerate

    // Carry chain is walked in one process so each block sees its own carry-in.
    always_comb begin
        logic blk_c;
        logic rip_c;
        sum   = '0;
        blk_c = cin;
        for (int blk = 0; blk < 4; blk++) begin
            rip_c = blk_c;
            for (int bit_i = 0; bit_i < 4; bit_i++) begin
                sum[4*blk + bit_i] = p_bit[4*blk + bit_i] ^ rip_c;
                rip_c = g_bit[4*blk + bit_i] | (p_bit[4*blk + bit_i] & rip_c);
            end
            blk_c = blk_prop[blk] ? blk_c : rip_c;
        end
        cout = blk_c;
    end

endmodule

// File: rtl/csa_wide_seq.sv
// Multi-cycle wide add/subtract: one 16-bit carry-skip slice per cycle, LSB first.
// Optional signed-overflow output enabled by defining CSA_SEQ_OVF_EN.
module csa_wide_seq
    import csa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*WORDS-1:0]     in_a,
    input  logic [16*WORDS-1:0]     in_b,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*WORDS-1:0]     out_sum,
    output logic                    out_cout
`ifdef CSA_SEQ_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    csa_state_t         state_reg;
    csa_state_t         state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       sum_reg;
    logic               cout_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last_slice;

    assign accept     = in_valid && in_ready_reg;
    assign last_slice = (idx_reg == IDX_LAST);
    assign slice_a    = a_reg[idx_reg*SLICE_W +: SLICE_W];
    assign slice_b    = b_reg[idx_reg*SLICE_W +: SLICE_W];

    csa_slice16 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == IDLE);
            out_valid_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b ^ {W{in_sub}};
                        carry_reg <= in_sub;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        cout_reg <= slice_cout;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_SEQ_OVF_EN
    logic ovf_reg;

    // Operands agree in sign but the result sign differs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_slice) begin
            ovf_reg <= (a_reg[W-1] ~^ b_reg[W-1]) & (a_reg[W-1] ^ slice_sum[SLICE_W-1]);
        end
    end

    assign out_ovf = ovf_reg;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;

endmodule

// File: doc/csa_wide_seq.md
# csa_wide_seq

Multi-cycle wide add/subtract sequencer. It time-shares a single 16-bit carry-skip adder slice across an operand of `16*WORDS` bits, one 16-bit slice per cycle, from least to most significant. The slice carry is chained through a register between cycles. The block sits between a requester and a consumer, with valid/ready handshakes on both sides. It lets the team build 32/64/128-bit adders without replicating the 16-bit carry-skip datapath.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Legal range is 1..16. Operand width `W = 16*WORDS`.
- `clk`, input, 1: the only clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: request accepted when `in_valid && in_ready` at a rising edge.
- `in_a`, input, W: operand A.
- `in_b`, input, W: operand B.
- `in_sub`, input, 1: 0 = A+B, 1 = A−B.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, W: result.
- `out_cout`, output, 1: carry out of the MSB slice.
- `out_ovf`, output, 1: two's-complement overflow. Present only with `CSA_SEQ_OVF_EN`.

## Operation
FSM states: IDLE, RUN, DONE.

- **IDLE**
  - `in_ready`=1.
  - On accept: capture `in_a`, `in_b ^ {W{in_sub}}` and `in_sub`; set `carry` ← `in_sub`; set `idx` ← 0; go to RUN.
- **RUN**
  - `in_ready`=0.
  - Each cycle the slice adds `a[idx]`, `b[idx]` and `carry`.
  - The slice sum is written to `out_sum[16*idx +: 16]`, and `carry` ← slice cout.
  - When `idx == WORDS-1`: latch `out_cout` and go to DONE. Otherwise `idx++`.
- **DONE**
  - `out_valid`=1.
  - `out_sum`, `out_cout` and `out_ovf` are held stable while `out_ready`=0.
  - On `out_ready`=1: go to IDLE.

Arithmetic rules:
- Subtract is A + ~B + 1, and `out_cout` is the raw carry. A ≥ B unsigned gives `out_cout`=1.
- `out_sum` is W bits, modulo 2^W.
- `idx` width is `$clog2(WORDS)`, minimum 1 bit.

Boundary conditions:
- `in_valid` while in RUN or DONE is ignored. No queueing; the requester must hold its request.
- `out_ready` outside DONE is ignored.
- `WORDS`=1: RUN lasts exactly one cycle.

Reset:
- `rst_n`=0 at any edge forces IDLE.
- `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `carry`=0, `idx`=0.
- `in_ready`=0 during the reset cycle and 1 from the first edge with `rst_n`=1.
- A reset during RUN discards the partial result, and no `out_valid` is produced.

## Timing
- Accept at edge E0. RUN occupies the cycles after E0..E(WORDS−1).
- `out_valid` rises after edge E(WORDS), so latency is WORDS cycles from acceptance.
- The output handshake at edge Ek returns to IDLE, and `in_ready`=1 in the following cycle.
- Throughput with `out_ready` tied high is one operation per WORDS+2 cycles.
- All outputs are registered. The slice is the only combinational path, on register → slice → register.

## Configuration
- `CSA_SEQ_OVF_EN` defined:
  - `out_ovf` port exists.
  - It is latched in the last RUN cycle as `a_msb ~^ b_eff_msb) & (a_msb ^ sum_msb)`, where `b_eff` is the inverted-if-subtract operand.
- Not defined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `csa_pkg`:
  - `SLICE_W = 16`.
  - `csa_state_t` enum (IDLE, RUN, DONE).
  - `MAX_WORDS = 16`.
- One sub-module, `csa_slice16`:
  - A 16-bit carry-skip adder with carry-in.
  - Four 4-bit ripple blocks, each with a propagate-based skip mux.
  - Ports: `a[15:0]`, `b[15:0]`, `cin`, `sum[15:0]`, `cout`.
- The sequencer instantiates exactly one `csa_slice16`.

## Test plan
All scenarios use WORDS=4.

- **Full carry ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=1, add → `out_sum`=0, `out_cout`=1, `out_valid` exactly 4 cycles after accept.
- **Subtract, A ≥ B:** A=0x0000_0001_0000_0000, B=1, sub → `out_sum`=0x0000_0000_FFFF_FFFF, `out_cout`=1.
- **Subtract, A < B:** A=0, B=1, sub → `out_sum`=0xFFFF_FFFF_FFFF_FFFF, `out_cout`=0.
- **Signed overflow** (with `CSA_SEQ_OVF_EN`): A=0x7FFF_FFFF_FFFF_FFFF, B=1, add → `out_ovf`=1 and `out_sum`=0x8000_0000_0000_0000. Then 5+3 → `out_ovf`=0.
- **Backpressure and no queueing:** hold `out_ready`=0 for 10 cycles in DONE → `out_sum` stable, `in_ready`=0 throughout, and a second request held on `in_valid` is accepted only the cycle after the output handshake.
- **Reset mid-RUN:** `rst_n`=0 after slice 1 completes → IDLE next cycle, all outputs 0, no `out_valid`. The next request 2+2 yields 4.
